// File: rtl/cpu_bus_scheduler.sv
// Shared CPU memory bus arbiter with an OAM DMA engine.
// Priority is DMA > interrupt handler > instruction executor.
module cpu_bus_scheduler #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ie_addr,
  input  logic [7:0]  ie_data_out,
  input  logic        ie_write_en,
  input  logic [15:0] ih_addr,
  input  logic [7:0]  ih_data_out,
  input  logic        ih_write_en,
  input  logic        ih_busy,
  input  logic [7:0]  cpu_data_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_write_en,
  output logic        ie_stall,
  output logic        ih_grant,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    StIdle,
    StAlign0,
    StAlign1,
    StRead,
    StWrite,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic       parity_q;
  logic       trigger;
  logic       bus_we;

  // Only an executor-owned write can start a transfer; a busy handler masks it.
  assign trigger = (state_q == StIdle) && !ih_busy && ie_write_en &&
                   (ie_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      parity_q <= ~parity_q;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          page_d  = ie_data_out;
          idx_d   = 8'h00;
          state_d = StAlign0;
        end
      end
      // An odd-parity start costs one extra alignment cycle.
      StAlign0: state_d = parity_q ? StAlign1 : StRead;
      StAlign1: state_d = StRead;
      StRead:   state_d = StWrite;
      StWrite: begin
        idx_d   = idx_q + 8'h01;
        state_d = (idx_q == 8'hFF) ? StDone : StRead;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    dma_active   = (state_q != StIdle);
    dma_done     = (state_q == StDone);
    ih_grant     = ih_busy && !dma_active;
    ie_stall     = dma_active || ih_busy;
    mem_addr     = ie_addr;
    mem_data_out = ie_data_out;
    bus_we       = ie_write_en;
    if (dma_active) begin
      mem_addr     = 16'h0000;
      mem_data_out = 8'h00;
      bus_we       = 1'b0;
      if (state_q == StRead) begin
        mem_addr = {page_q, idx_q};
      end else if (state_q == StWrite) begin
        mem_addr     = OAM_DATA_ADDR;
        mem_data_out = cpu_data_in;
        bus_we       = 1'b1;
      end
    end else if (ih_busy) begin
      mem_addr     = ih_addr;
      mem_data_out = ih_data_out;
      bus_we       = ih_write_en;
    end
    mem_write_en = bus_we && rst;
  end

endmodule

// File: tb/tb_cpu_bus_scheduler.sv
// Directed bench for cpu_bus_scheduler: idle-arbitration vector table plus
// hand-written DMA sequences (parity 0/1, handler during DMA, reset abort).
module tb_cpu_bus_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ie_addr;
  logic [7:0]  ie_data_out;
  logic        ie_write_en;
  logic [15:0] ih_addr;
  logic [7:0]  ih_data_out;
  logic        ih_write_en;
  logic        ih_busy;
  logic [7:0]  cpu_data_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_write_en;
  logic        ie_stall;
  logic        ih_grant;
  logic        dma_active;
  logic        dma_done;

  int n_vec = 0;
  int n_bad = 0;
  int edges;

  cpu_bus_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .ie_addr      (ie_addr),
    .ie_data_out  (ie_data_out),
    .ie_write_en  (ie_write_en),
    .ih_addr      (ih_addr),
    .ih_data_out  (ih_data_out),
    .ih_write_en  (ih_write_en),
    .ih_busy      (ih_busy),
    .cpu_data_in  (cpu_data_in),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_write_en (mem_write_en),
    .ie_stall     (ie_stall),
    .ih_grant     (ih_grant),
    .dma_active   (dma_active),
    .dma_done     (dma_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Memory model: read data valid one cycle after the address.
  always @(posedge clk) cpu_data_in <= mem_f(mem_addr);

  // Edges since reset release; the DUT parity bit equals edges mod 2.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] ie_a;
    logic [7:0]  ie_d;
    logic        ie_w;
    logic [15:0] ih_a;
    logic [7:0]  ih_d;
    logic        ih_w;
    logic        busy;
    logic [15:0] x_addr;
    logic [7:0]  x_data;
    logic        x_we;
    logic        x_stall;
    logic        x_grant;
  } vec_t;

  vec_t vecs[8];

  task automatic dma_run(input logic [7:0] pg, input int want_par, input int exp_stall,
                         input bit ih_mid);
    int stall = 0;
    int wr = 0;
    int bad = 0;
    int done_n = 0;
    int grant_n = 0;
    int n;
    logic [15:0] last = 16'h0000;
    @(negedge clk);
    if (((edges + 1) % 2) != want_par) @(negedge clk);
    ie_addr = 16'h4014; ie_data_out = pg; ie_write_en = 1'b1;
    #1;
    chk("trigger_write", 32'({mem_write_en, mem_addr, mem_data_out}), 32'({1'b1, 16'h4014, pg}));
    chk("trigger_no_stall", 32'(ie_stall), 32'd0);
    @(negedge clk);
    ie_write_en = 1'b0; ie_addr = 16'h0777; ie_data_out = 8'h00;
    for (n = 0; n < 700; n++) begin
      #1;
      if (!dma_active) break;
      stall += int'(ie_stall);
      done_n += int'(dma_done);
      grant_n += int'(ih_grant);
      if (mem_write_en) begin
        if (mem_addr != 16'h2004 || mem_data_out != mem_f({pg, wr[7:0]}) ||
            last != {pg, wr[7:0]}) bad++;
        wr++;
      end
      if (ih_mid && !ih_busy && wr == 64 && !mem_write_en && mem_addr == {pg, 8'h40}) begin
        ih_busy = 1'b1; ih_addr = 16'h1234; ih_data_out = 8'h5C; ih_write_en = 1'b1;
      end
      last = mem_addr;
      @(negedge clk);
    end
    chk("dma_timeout", 32'(n < 700), 32'd1);
    chk("dma_stall_cycles", 32'(stall), 32'(exp_stall));
    chk("dma_write_count", 32'(wr), 32'd256);
    chk("dma_write_errors", 32'(bad), 32'd0);
    chk("dma_done_pulses", 32'(done_n), 32'd1);
    chk("ih_grant_during_dma", 32'(grant_n), 32'd0);
    if (ih_mid) begin
      chk("ih_grant_after_dma", 32'({ih_grant, mem_addr, mem_data_out, mem_write_en}),
          32'({1'b1, 16'h1234, 8'h5C, 1'b1}));
      ih_busy = 1'b0; ih_write_en = 1'b0;
    end else begin
      chk("idle_after_dma", 32'({ie_stall, dma_active, mem_addr}), 32'({1'b0, 1'b0, 16'h0777}));
    end
  endtask

  initial begin
    vecs[0] = '{16'h4013, 8'h11, 1'b1, 16'h1000, 8'h22, 1'b0, 1'b0, 16'h4013, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h4015, 8'h33, 1'b1, 16'h1000, 8'h22, 1'b1, 1'b0, 16'h4015, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 8'h00, 1'b0, 16'h1111, 8'h99, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 8'h44, 1'b0, 16'h2000, 8'h55, 1'b1, 1'b1, 16'h2000, 8'h55, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{16'h4014, 8'h02, 1'b1, 16'h0300, 8'h66, 1'b0, 1'b1, 16'h0300, 8'h66, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 8'hAA, 1'b1, 16'h4014, 8'h07, 1'b1, 1'b1, 16'h4014, 8'h07, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFF, 8'hFF, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 16'hFFFF, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h4014, 8'h05, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h4014, 8'h05, 1'b0, 1'b0, 1'b0};

    // Reset state, with a would-be trigger and a busy handler on the inputs.
    rst = 1'b0;
    ie_addr = 16'h4014; ie_data_out = 8'h02; ie_write_en = 1'b1;
    ih_addr = 16'h0100; ih_data_out = 8'h00; ih_write_en = 1'b1; ih_busy = 1'b1;
    #1;
    chk("reset_busy", 32'({mem_write_en, ie_stall, ih_grant, dma_active, dma_done}),
        32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
    ih_busy = 1'b0;
    #1;
    chk("reset_idle", 32'({mem_write_en, ie_stall, ih_grant, dma_active, dma_done, mem_addr}),
        32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4014}));
    repeat (2) @(negedge clk);
    ie_write_en = 1'b0; ih_write_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(dma_active), 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      ie_addr = vecs[i].ie_a; ie_data_out = vecs[i].ie_d; ie_write_en = vecs[i].ie_w;
      ih_addr = vecs[i].ih_a; ih_data_out = vecs[i].ih_d; ih_write_en = vecs[i].ih_w;
      ih_busy = vecs[i].busy;
      #1;
      chk($sformatf("vec%0d_bus", i),
          32'({mem_addr, mem_data_out, mem_write_en, ie_stall, ih_grant, dma_active}),
          32'({vecs[i].x_addr, vecs[i].x_data, vecs[i].x_we, vecs[i].x_stall,
               vecs[i].x_grant, 1'b0}));
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_no_dma", i), 32'({dma_active, dma_done}), 32'd0);
    end
    @(negedge clk);
    ie_write_en = 1'b0; ih_write_en = 1'b0; ih_busy = 1'b0;

    dma_run(8'h02, 0, 514, 1'b0);
    dma_run(8'h02, 1, 515, 1'b0);
    dma_run(8'h05, 0, 514, 1'b1);

    // Reset in the WRITE cycle for idx 8'h80 aborts the transfer.
    begin
      int wr = 0;
      int n;
      int junk = 0;
      @(negedge clk);
      ie_addr = 16'h4014; ie_data_out = 8'h03; ie_write_en = 1'b1;
      @(negedge clk);
      ie_write_en = 1'b0; ie_addr = 16'h0777;
      for (n = 0; n < 700; n++) begin
        #1;
        if (mem_write_en && wr == 128) begin
          rst = 1'b0;
          #1;
          chk("abort_now", 32'({mem_write_en, dma_active, dma_done, ie_stall, ih_grant}), 32'd0);
          break;
        end
        if (mem_write_en) wr++;
        @(negedge clk);
      end
      chk("abort_reached", 32'(n < 700), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      repeat (20) begin
        @(negedge clk);
        #1;
        junk += int'(dma_done) + int'(dma_active) + int'(mem_write_en);
      end
      chk("abort_quiet", 32'(junk), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_scheduler.md
CPU_BUS_SCHEDULER -- requirements
Module: cpu_bus_scheduler

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014: CPU address whose write triggers OAM DMA.
REQ-002 Parameter OAM_DATA_ADDR, default 16'h2004: PPU OAM data port that is the DMA write target.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ie_addr / ie_data_out / ie_write_en  input  16/8/1  instruction-executor bus request.
REQ-006 ih_addr / ih_data_out / ih_write_en  input  16/8/1  interrupt-handler bus request.
REQ-007 ih_busy  input  1  interrupt handler requests the bus (its accessing_memory).
REQ-008 cpu_data_in  input  8  memory read data, valid one cycle after its address is presented.
REQ-009 mem_addr / mem_data_out / mem_write_en  output  16/8/1  shared memory bus.
REQ-010 ie_stall  output  1  executor must hold its state; its bus request is ignored.
REQ-011 ih_grant  output  1  handler owns the bus this cycle.
REQ-012 dma_active  output  1  DMA engine owns the bus.
REQ-013 dma_done  output  1  one-cycle pulse after the final OAM write.

Function
REQ-014 Bus owner priority, combinational: DMA (state != IDLE) > handler (ih_busy) > executor.
REQ-015 ih_grant = ih_busy & !dma_active; ie_stall = dma_active | ih_busy.
REQ-016 mem_* is a combinational mux of the owner's signals; mem_write_en is forced 0 while rst is low.
REQ-017 States: IDLE, ALIGN0, ALIGN1, READ, WRITE, DONE.
REQ-018 Parity bit: cleared by reset and toggled every cycle; it records cycle parity.
REQ-019 Trigger: in IDLE, when executor is owner, ie_write_en=1 and ie_addr==DMA_REG_ADDR, then page <= ie_data_out, idx <= 0, and next state = ALIGN0; the trigger write itself still reaches memory that cycle.
REQ-020 A trigger is ignored when ih_busy=1, since the executor is not the owner.
REQ-021 ALIGN0: mem_write_en=0. Next state is ALIGN1 if parity=1 in this cycle, else READ.
REQ-022 ALIGN1: mem_write_en=0. Next state is READ.
REQ-023 READ: mem_addr={page,idx}, mem_write_en=0. Next state is WRITE.
REQ-024 WRITE: mem_addr=OAM_DATA_ADDR, mem_data_out=cpu_data_in (pass-through), mem_write_en=1, idx <= idx+1 (8-bit).
REQ-025 WRITE exit: if idx was 8'hFF, next state is DONE (idx wraps to 0); otherwise next state is READ.
REQ-026 DONE: dma_done=1, dma_active=1, mem_write_en=0. Next state is IDLE.
REQ-027 Executor stall from the cycle after the trigger write to the end of DONE is 514 cycles (parity 0 in ALIGN0) or 515 cycles (parity 1).
REQ-028 If ih_busy asserts during DMA, the handler waits (ih_grant=0) and is granted in the first IDLE cycle.
REQ-029 A DMA_REG_ADDR write from the handler never triggers DMA.
REQ-030 Page 8'h20–8'h3F reads are not special-cased; the addresses are issued as computed.

Reset
REQ-031 On rst low, immediately: state=IDLE, page=0, idx=0, parity=0; dma_active=0, dma_done=0, ie_stall=ih_busy, ih_grant=ih_busy, mem_write_en=0.
REQ-032 A reset asserted mid-DMA aborts the transfer; no further OAM writes occur and there is no dma_done pulse.
REQ-033 After rst deasserts, the first rising edge evaluates from IDLE.

Verification
REQ-034 Executor writes 8'h02 to 16'h4014 with parity 0 in ALIGN0 -> 256 READ/WRITE pairs (16'h0200..16'h02FF to 16'h2004), OAM receives memory bytes in order, dma_done pulses once, ie_stall is high for 514 cycles.
REQ-035 Same trigger with parity 1 in ALIGN0 -> ALIGN1 is visited and ie_stall is high for 515 cycles.
REQ-036 ih_busy rises in READ at idx=8'h40 -> ih_grant stays 0 until IDLE; DMA completes unaltered; then ih_grant=1 with mem_addr=ih_addr.
REQ-037 Executor writes to 16'h4014 while ih_busy=1 -> no DMA, dma_active stays 0, and the mem bus carries the handler request.
REQ-038 rst pulsed low in WRITE at idx=8'h80 -> mem_write_en=0 immediately, state=IDLE, and there is no dma_done pulse.
REQ-039 Idle traffic with ie_write_en=1 to 16'h4013 and 16'h4015 -> no trigger; mem_* equals ie_* every cycle.
